// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light front end: debounce defaults and
// direction encoding common with the light controller.
package traffic_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT           = 3;
  localparam int unsigned NUM_DIRS                = 2;

  // Must match the light controller's state encoding.
  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

endpackage : traffic_pkg

// File: rtl/sensor_debounce.sv
// One loop-detector channel: 2-flop synchronizer, stability counter and a
// demand latch that only the direction's green can clear.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  input  logic lite,
  output logic car
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;

  // Debounce counter and request latch next-state.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    req_d = req_q;

    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A present car always wins over a green; a departed car waits for green.
    if (deb_q) begin
      req_d = 1'b1;
    end else if (lite) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign car = req_q;

endmodule : sensor_debounce

// File: rtl/car_sensor_conditioner.sv
// Conditions the EW and NS loop detectors into latched, registered car
// demands for the light controller; the two channels are fully independent.
module car_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ew_sensor_raw,
  input  logic ns_sensor_raw,
  input  logic EWLite,
  input  logic NSLite,
  output logic EWCar,
  output logic NSCar
);

  logic [NUM_DIRS-1:0] raw_vec;
  logic [NUM_DIRS-1:0] lite_vec;
  logic [NUM_DIRS-1:0] car_vec;

  assign raw_vec[DIR_EW]  = ew_sensor_raw;
  assign raw_vec[DIR_NS]  = ns_sensor_raw;
  assign lite_vec[DIR_EW] = EWLite;
  assign lite_vec[DIR_NS] = NSLite;

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_chan
    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (raw_vec[d]),
      .lite    (lite_vec[d]),
      .car     (car_vec[d])
    );
  end

  assign EWCar = car_vec[DIR_EW];
  assign NSCar = car_vec[DIR_NS];

endmodule : car_sensor_conditioner

// File: tb/tb_car_sensor_conditioner.sv
// Directed scoreboard bench: each driven cycle queues the hand-derived
// EWCar/NSCar expected after that edge; a negedge monitor pops and compares.
module tb_car_sensor_conditioner;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ew_sensor_raw = 1'b0;
  logic ns_sensor_raw = 1'b0;
  logic EWLite = 1'b0;
  logic NSLite = 1'b0;
  logic EWCar, NSCar;

  typedef struct {
    logic  ew;
    logic  ns;
    string tag;
    int    idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  car_sensor_conditioner dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ew_sensor_raw (ew_sensor_raw),
    .ns_sensor_raw (ns_sensor_raw),
    .EWLite        (EWLite),
    .NSLite        (NSLite),
    .EWCar         (EWCar),
    .NSCar         (NSCar)
  );

  // Drive one cycle of inputs, then queue the outputs expected after its edge.
  task automatic step(input logic ew, input logic ns, input logic ewl,
                      input logic nsl, input logic rst_n, input logic exp_ew,
                      input logic exp_ns, input string tag, input int idx);
    exp_t e;
    @(negedge clock);
    ew_sensor_raw = ew;
    ns_sensor_raw = ns;
    EWLite        = ewl;
    NSLite        = nsl;
    reset_n       = rst_n;
    @(posedge clock);
    e.ew  = exp_ew;
    e.ns  = exp_ns;
    e.tag = tag;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset", i);
  endtask

  // Monitor: outputs are stable at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (EWCar === e.ew) n_pass++;
        else $display("FAIL %s[%0d] EWCar got %b expected %b", e.tag, e.idx, EWCar, e.ew);
        n_checks++;
        if (NSCar === e.ns) n_pass++;
        else $display("FAIL %s[%0d] NSCar got %b expected %b", e.tag, e.idx, NSCar, e.ns);
      end
    end
  end

  initial begin
    // Reset held with both cars present, then release: Car at release edge + 6.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, "rst_raw1", i);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 1, i >= 6, i >= 6, "rst_release", i);
    // Reset drops latched requests on the first low edge.
    do_reset(2);

    // 3-cycle glitch is rejected.
    for (int i = 0; i < 11; i++) step(i < 3, 0, 0, 0, 1, 0, 0, "glitch3", i);
    // 4-cycle pulse: deb at edge 5, Car at edge 6, latched until EWLite with deb low.
    for (int i = 0; i < 14; i++) begin
      logic lite_i;
      lite_i = (i == 12);
      step(i < 4, 0, lite_i, 0, 1, (i >= 6) && (i < 12), 0, "pulse4", i);
    end
    do_reset(2);

    // Bounce 1,0,1,1,0 then hold 1: final rise at step 5, Car at step 11.
    for (int i = 0; i < 14; i++) begin
      logic r;
      logic [4:0] pat;
      pat = 5'b01101;
      r = (i < 5) ? pat[i] : 1'b1;
      step(r, 0, 0, 0, 1, i >= 11, 0, "bounce", i);
    end
    do_reset(2);

    // NS car present 10 cycles then leaves: demand held until NSLite.
    for (int i = 0; i < 21; i++) begin
      logic lite_i;
      lite_i = (i == 19);
      step(0, i < 10, 0, lite_i, 1, 0, (i >= 6) && (i < 19), "latch_clear", i);
    end
    do_reset(2);

    // Queued car under a steady green keeps demand; falls 6 edges after raw drops.
    for (int i = 0; i < 34; i++)
      step(0, i < 26, 0, 1, 1, 0, (i >= 6) && (i < 32), "queued", i);
    do_reset(2);

    // Independence: NS one cycle behind EW; then both greens with cars present.
    for (int i = 0; i < 12; i++) begin
      logic both_lite;
      both_lite = (i >= 10);
      step(1, i >= 1, both_lite, both_lite, 1, i >= 6, i >= 7, "indep", i);
    end
    // Both greens with cars gone: each channel clears after deb falls (edge 5 + 1).
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, i < 6, i < 6, "both_lite_clear", i);
    do_reset(2);

    // Reset mid-count discards progress; full latency re-applies after release.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 0, 0, "midcount", i);
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0, 0, 0, "midcount_rst", i);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 1, i >= 6, i >= 6, "midcount_rel", i);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
    @(posedge clock);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_car_sensor_conditioner

// File: doc/car_sensor_conditioner.md
CAR_SENSOR_CONDITIONER -- requirements
Module: car_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required before the debounced level changes; legal range 2..7.
REQ-002 Parameter CNT_W, default 3: debounce counter width; SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 ew_sensor_raw  input  1  asynchronous, possibly bouncing, east-west loop detector.
REQ-006 ns_sensor_raw  input  1  asynchronous, possibly bouncing, north-south loop detector.
REQ-007 EWLite  input  1  east-west green from the downstream light controller; acts as the service acknowledge for EW.
REQ-008 NSLite  input  1  north-south green from the downstream light controller; acts as the service acknowledge for NS.
REQ-009 EWCar  output  1  registered, latched east-west demand to the light controller.
REQ-010 NSCar  output  1  registered, latched north-south demand to the light controller.

Function
REQ-011 Each channel (EW, NS) SHALL be processed independently and identically; there SHALL be no cross-channel interaction.
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer (sync1 <= raw, sync2 <= sync1) before any other use.
REQ-013 Each channel SHALL hold a debounced level deb and a counter cnt.
- When sync2 == deb: cnt <= 0.
- When sync2 != deb and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
- When sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync2 and cnt <= 0.
REQ-014 Any sync2 disagreement lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave deb unchanged. A return to agreement SHALL restart the count from 0.
REQ-015 Each channel's request register req SHALL follow these per-cycle priorities:
- deb == 1: set req.
- deb == 0 and the channel's Lite == 1: clear req.
- Otherwise: hold req.
REQ-016 EWCar SHALL equal req_ew and NSCar SHALL equal req_ns, driven directly from flops with no combinational path from any input.
REQ-017 Latency: a raw rising level first sampled at edge 0 and held stable SHALL give deb high after edge 1+DEBOUNCE_CYCLES and Car high after edge 2+DEBOUNCE_CYCLES. Falling transitions SHALL have the same latency to deb.
REQ-018 A car that is debounced-present and then leaves before its green SHALL keep Car asserted until that direction's Lite is seen high while deb is low.
REQ-019 Lite high while deb is high SHALL NOT clear req: a queued car keeps demand asserted.
REQ-020 Both Lite inputs high in the same cycle (illegal upstream) SHALL be tolerated with no special handling: each channel applies REQ-015 independently.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 While reset_n == 0 at a rising edge, the following SHALL all be loaded with 0: sync1, sync2, cnt, deb and req for both channels. EWCar and NSCar SHALL be 0 from the first edge with reset_n low.
REQ-023 Reset asserted mid-debounce or with a latched request SHALL discard all progress. After release, detection SHALL restart with the full REQ-017 latency.

Structure
REQ-024 The shared package traffic_pkg SHALL hold:
- DEBOUNCE_CYCLES_DEFAULT = 4.
- CNT_W_DEFAULT = 3.
- Direction encoding DIR_NS = 0, DIR_EW = 1, matching the light controller's state encoding.
REQ-025 One sub-module, sensor_debounce, SHALL implement one channel (synchronizer, debounce, request latch). It SHALL have ports clock, reset_n, raw, lite and car, and SHALL be instantiated twice.

Verification
REQ-026 Reset with both raw = 1: hold reset_n = 0 for 3 edges -> EWCar = NSCar = 0 throughout. Release reset_n -> EWCar rises exactly after release edge + 6 (DEBOUNCE_CYCLES = 4).
REQ-027 Glitch rejection: ew_sensor_raw pulse 3 cycles wide -> EWCar stays 0. Pulse 4 cycles wide -> EWCar = 1 at edge 6.
REQ-028 Bounce: ew_sensor_raw toggles 1,0,1,1,0 then holds 1 -> EWCar rises 6 edges after the final 0->1 transition.
REQ-029 Latch and clear: NS car present for 10 cycles then gone, NSLite = 0 -> NSCar stays 1. NSLite = 1 for one cycle -> NSCar = 0 on the next edge.
REQ-030 Queued car: ns_sensor_raw held 1 and NSLite = 1 for 20 cycles -> NSCar stays 1. Drop raw -> NSCar falls 6 edges later (5 to deb, 1 to req).
REQ-031 Independence: EW and NS stimulated simultaneously with 1-cycle offset -> outputs rise 1 cycle apart. Reset asserted mid-count -> both outputs 0 and the full latency re-applies after release.
